// File: rtl/arith_pkg.sv
// arith_pkg: divider FSM state encoding (IDLE=0..DONE=4) and clog2 counter-width helper
package arith_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, FIX = 3'd3, DONE = 3'd4} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/signed_nr_divider_if.sv
// signed_nr_divider_if: divider bus; master drives start/dividend/divisor, slave returns busy/done/quotient/remainder/div_by_zero/overflow
interface signed_nr_divider_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic busy;
  logic done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic div_by_zero;
  logic overflow;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero, overflow);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero, overflow);
endinterface

// File: rtl/nr_addsub.sv
// nr_addsub: W-bit adder/subtractor; ports a, b, sub (1 = a-b, 0 = a+b) -> y
module nr_addsub #(parameter int W = 9) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);
  assign y = sub ? a - b : a + b;
endmodule

// File: rtl/signed_nr_divider.sv
// signed_nr_divider: sequential signed non-restoring divider, one quotient bit per clock; ports clk, rst, io (slave: start/dividend/divisor in, busy/done/quotient/remainder/div_by_zero/overflow out)
module signed_nr_divider import arith_pkg::*; #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  signed_nr_divider_if.slave io
);
  localparam int CW = clog2(WIDTH);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] p, sh, pn;
  logic [WIDTH-1:0] q, d, pc, nq, nr, abs_n, abs_d;
  logic sn, sd, ovp, accept, zero;
  always_comb begin
    accept = (state == IDLE || state == DONE) && io.start;
    zero = io.divisor == '0;
    abs_n = io.dividend[WIDTH-1] ? -io.dividend : io.dividend;
    abs_d = io.divisor[WIDTH-1] ? -io.divisor : io.divisor;
    nxt = accept ? (zero ? DONE : LOAD) :
          state == LOAD ? RUN :
          state == RUN ? (cnt == CW'(WIDTH - 1) ? FIX : RUN) :
          state == FIX ? DONE : IDLE;
  end
  assign sh = {p[WIDTH-1:0], q[WIDTH-1]};
  assign pc = p[WIDTH] ? pn[WIDTH-1:0] : p[WIDTH-1:0];
  nr_addsub #(.W(WIDTH + 1)) u_step (.a(state == RUN ? sh : p), .b({1'b0, d}), .sub(state == RUN && !p[WIDTH]), .y(pn));
  nr_addsub #(.W(WIDTH)) u_negq (.a('0), .b(q), .sub(1'b1), .y(nq));
  nr_addsub #(.W(WIDTH)) u_negr (.a('0), .b(pc), .sub(1'b1), .y(nr));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      io.busy <= 1'b0;
      io.done <= 1'b0;
      io.quotient <= '0;
      io.remainder <= '0;
      io.div_by_zero <= 1'b0;
      io.overflow <= 1'b0;
    end else begin
      state <= nxt;
      io.busy <= nxt inside {LOAD, RUN, FIX};
      io.done <= nxt == DONE;
      if (accept) begin
        io.div_by_zero <= zero;
        io.overflow <= 1'b0;
        q <= abs_n;
        d <= abs_d;
        sn <= io.dividend[WIDTH-1];
        sd <= io.divisor[WIDTH-1];
        ovp <= io.dividend == {1'b1, {(WIDTH - 1){1'b0}}} && &io.divisor;
        if (zero) begin
          io.quotient <= '1;
          io.remainder <= io.dividend;
        end
      end
      if (state == LOAD) begin
        p <= '0;
        cnt <= '0;
      end
      if (state == RUN) begin
        p <= pn;
        q <= {q[WIDTH-2:0], ~pn[WIDTH]};
        cnt <= cnt + CW'(1);
      end
      if (state == FIX) begin
        io.quotient <= (sn ^ sd) ? nq : q;
        io.remainder <= sn ? nr : pc;
        io.overflow <= ovp;
      end
    end
  end
endmodule
